// File: rtl/uart_hist_scan_pkg.sv
// Shared types and derived-constant helpers for the uart_hist_scan block.
package uart_hist_scan_pkg;

  // Receiver states: WAIT_HI holds off after a framing error until the line idles.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

  // Transmitter states, one per frame section.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Clocks per bit; the caller must keep the result >= 4.
  function automatic int calc_div(input int clk_frq, input int baud);
    return clk_frq / baud;
  endfunction

  // Two hex digits per history byte.
  function automatic int calc_ndig(input int depth);
    return 2 * depth;
  endfunction

endpackage

// File: rtl/uart_hist_scan_if.sv
// Pin-level bundle between the board side (RS-232 pins, LED digit driver) and the core.
interface uart_hist_scan_if #(
  parameter int NDIG = 8
);
  logic            rx;
  logic            echo_en;
  logic            err_clr;
  logic            tx;
  logic            tx_busy;
  logic            ledr;
  logic            frm_err;
  logic            ovr;
  logic [3:0]      dbus;
  logic [NDIG-1:0] sbus;

  // Board side: drives the serial input and controls, observes everything else.
  modport master (
    output rx, echo_en, err_clr,
    input  tx, tx_busy, ledr, frm_err, ovr, dbus, sbus
  );

  // Core side.
  modport slave (
    input  rx, echo_en, err_clr,
    output tx, tx_busy, ledr, frm_err, ovr, dbus, sbus
  );
endinterface

// File: rtl/uart_hist_scan_tx_ser.sv
// DIV-timed 8N1 serialiser: a load pulse in IDLE starts a frame; busy covers start..stop.
module uart_hist_scan_tx_ser
  import uart_hist_scan_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);
  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_tx;
  logic          r_busy;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == BIT_LAST);

  // Frame sequencer: every section lasts exactly DIV clocks, tx and busy are registered.
  // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_cnt <= (r_state == TX_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
      case (r_state)
        TX_IDLE: begin
          if (i_load) begin
            r_state <= TX_START;
            r_sh    <= i_data;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_state <= TX_DATA;
            r_bit   <= '0;
            r_tx    <= r_sh[0];
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              // Present the next bit while dropping the one just sent.
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_sh[1];
              r_sh  <= {1'b0, r_sh[7:1]};
            end
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_state <= TX_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;

endmodule

// File: rtl/uart_hist_scan.sv
// Single-clock serial front-end: RX deserialiser with false-start/framing checks,
// optional echo through the TX serialiser, a DEPTH-byte history and a hex digit scan.
module uart_hist_scan
  import uart_hist_scan_pkg::*;
#(
  parameter int CLK_FRQ  = 25000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 4,
  parameter int SCAN_DIV = 25000
) (
  input  logic           clk,
  input  logic           rst,
  uart_hist_scan_if.slave bus
);
  localparam int DIV  = calc_div(CLK_FRQ, BAUD);
  localparam int NDIG = calc_ndig(DEPTH);
  localparam int CW   = $clog2(DIV);
  localparam int HW   = $clog2(DEPTH);  // history index; DEPTH must be >= 2
  localparam int DW   = HW + 1;         // digit index, equals $clog2(NDIG)
  localparam int SW   = $clog2(SCAN_DIV + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NDIG - 1);

  // ---------------------------------------------------------------- RX
  logic          r_rx_s1;
  logic          r_rx_s2;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_byte_vld;  // one-clock pulse after a good stop sample
  logic          r_frm_set;   // one-clock pulse after a bad stop sample

  // Two-flop synchroniser; idles high like the line so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Receive FSM: mid-start recheck, eight mid-bit samples LSB first, then the stop sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_byte_vld <= 1'b0;
      r_frm_set  <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_frm_set  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rx_s2) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            // Line back high at mid-start means a glitch, not a frame.
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_s2) begin
              r_byte_vld <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_frm_set  <= 1'b1;
              r_rx_state <= RX_WAIT_HI;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HI: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------ history, flags, echo
  logic [7:0] r_hist [DEPTH];
  logic       r_ledr;
  logic       r_frm_err;
  logic       r_ovr;
  logic       r_echo_ld;
  logic       w_tx;
  logic       w_tx_busy;
  logic       w_echo_req;

  assign w_echo_req = r_byte_vld & bus.echo_en;

  // History shift, activity LED, sticky error flags (set beats clear) and echo request.
  // NOTE: the history is a handful of flops, so it is reset like any other register; a RAM could not be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
      r_ledr    <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr     <= 1'b0;
      r_echo_ld <= 1'b0;
    end else begin
      r_echo_ld <= w_echo_req & ~w_tx_busy;
      if (r_byte_vld) begin
        for (int k = DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
        r_hist[0] <= r_rx_sh;
        r_ledr    <= ~r_ledr;
      end
      if (r_frm_set)        r_frm_err <= 1'b1;
      else if (bus.err_clr) r_frm_err <= 1'b0;
      if (w_echo_req && w_tx_busy) r_ovr <= 1'b1;
      else if (bus.err_clr)        r_ovr <= 1'b0;
    end
  end

  // The echoed byte is taken from hist[0], written the clock before the load pulse.
  uart_hist_scan_tx_ser #(
    .DIV (DIV)
  ) u_tx_ser (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_echo_ld),
    .i_data (r_hist[0]),
    .o_tx   (w_tx),
    .o_busy (w_tx_busy)
  );

  // -------------------------------------------------------------- scan
  logic [SW-1:0]   r_scan_cnt;
  logic            r_scan_on;   // first wrap after reset selects digit 0
  logic [DW-1:0]   r_digit;
  logic [3:0]      r_dbus;
  logic [NDIG-1:0] r_sbus;
  logic            w_scan_wrap;
  logic [DW-1:0]   w_next_digit;
  logic [7:0]      w_scan_byte;
  logic [3:0]      w_next_nib;

  // Next digit and its nibble, looked up from the history as it stands at the update.
  // NOTE: every always_comb output is assigned on every path (defaults first), so no latch is inferred.
  always_comb begin
    w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
    w_next_digit = '0;
    if (r_scan_on && r_digit != DIG_LAST) w_next_digit = r_digit + 1'b1;
    w_scan_byte  = r_hist[w_next_digit[DW-1:1]];
    w_next_nib   = w_next_digit[0] ? w_scan_byte[7:4] : w_scan_byte[3:0];
  end

  // Digit timer and registered select/data outputs, both refreshed on the same wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_scan_on  <= 1'b0;
      r_digit    <= '0;
      r_dbus     <= '0;
      r_sbus     <= '0;
    end else begin
      if (w_scan_wrap) begin
        r_scan_cnt <= '0;
        r_scan_on  <= 1'b1;
        r_digit    <= w_next_digit;
        r_dbus     <= w_next_nib;
        r_sbus     <= NDIG'(1) << w_next_digit;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  // ----------------------------------------------------------- outputs
  assign bus.tx      = w_tx;
  assign bus.tx_busy = w_tx_busy;
  assign bus.ledr    = r_ledr;
  assign bus.frm_err = r_frm_err;
  assign bus.ovr     = r_ovr;
  assign bus.dbus    = r_dbus;
  assign bus.sbus    = r_sbus;

endmodule

// File: tb/tb_uart_hist_scan.sv
// Bench for uart_hist_scan: DIV=10, DEPTH=4, SCAN_DIV=3. A queue model of the history,
// a toggle model of ledr and a line-level decoder of tx give every expected value.
module tb_uart_hist_scan;
  localparam int DIV      = 10;
  localparam int DEPTH    = 4;
  localparam int NDIG     = 8;
  localparam int SCAN_DIV = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_hist_scan_if #(.NDIG(NDIG)) bus ();

  uart_hist_scan #(
    .CLK_FRQ  (1000),
    .BAUD     (100),
    .DEPTH    (DEPTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: newest byte at the front of the queue.
  byte unsigned m_q[$];
  bit           m_ledr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void m_reset();
    m_q = {8'h00, 8'h00, 8'h00, 8'h00};
    m_ledr = 1'b0;
  endfunction

  function automatic void m_push(input byte unsigned b);
    m_q.push_front(b);
    if (m_q.size() > DEPTH) void'(m_q.pop_back());
    m_ledr = ~m_ledr;
  endfunction

  function automatic logic [3:0] m_nib(input int d);
    byte unsigned b;
    b = m_q[d / 2];
    return (d % 2 == 1) ? b[7:4] : b[3:0];
  endfunction

  // One 8N1 frame on rx; stop_low > 0 holds the stop bit low for that many clocks first.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    bus.rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(DIV);
    end
    if (stop_low > 0) begin
      bus.rx = 1'b0;
      tick(stop_low);
    end
    bus.rx = 1'b1;
    tick(DIV);
  endtask

  // Wait up to window clocks for a tx start bit; decode it mid-bit or confirm none appears.
  task automatic watch_tx(input bit exp_frame, input logic [7:0] b, input int window);
    int t;
    int busy_n;
    logic [9:0] got;
    t = 0;
    busy_n = 0;
    got = '1;
    while (bus.tx !== 1'b0 && t < window) begin
      @(negedge clk);
      t++;
    end
    if (exp_frame) begin
      check("echo_start", bus.tx, 1'b0);
      for (int c = 0; c < 10 * DIV + 4; c++) begin
        if (bus.tx_busy === 1'b1) busy_n++;
        if (c % DIV == DIV / 2) got[c / DIV] = bus.tx;
        @(negedge clk);
      end
      check("echo_frame", got, {1'b1, b, 1'b0});
      check("echo_busy_len", busy_n, 10 * DIV);
    end else begin
      check("no_echo", bus.tx, 1'b1);
    end
  endtask

  // Align on digit 0, then follow NDIG+1 updates: select, nibble and update spacing.
  task automatic check_scan(input string tag);
    int t;
    logic [NDIG-1:0] prev;
    logic [NDIG-1:0] exp_sel;
    t = 0;
    while (bus.sbus !== NDIG'(1) && t < 10 * NDIG * SCAN_DIV) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_align"}, bus.sbus, NDIG'(1));
    for (int k = 0; k <= NDIG; k++) begin
      exp_sel = NDIG'(1) << (k % NDIG);
      check({tag, "_sel"}, bus.sbus, exp_sel);
      check({tag, "_dbus"}, bus.dbus, m_nib(k % NDIG));
      if (k < NDIG) begin
        prev = bus.sbus;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (bus.sbus === prev && t < 4 * SCAN_DIV);
        if (k > 0) check({tag, "_period"}, t, SCAN_DIV);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},      bus.tx,      1'b1);
    check({tag, "_tx_busy"}, bus.tx_busy, 1'b0);
    check({tag, "_ledr"},    bus.ledr,    1'b0);
    check({tag, "_frm_err"}, bus.frm_err, 1'b0);
    check({tag, "_ovr"},     bus.ovr,     1'b0);
    check({tag, "_dbus"},    bus.dbus,    4'h0);
    check({tag, "_sbus"},    bus.sbus,    NDIG'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bit         re;

    bus.rx      = 1'b1;
    bus.echo_en = 1'b0;
    bus.err_clr = 1'b0;
    m_reset();

    // Reset values, in reset and one clock after release (before the first scan wrap).
    tick(3);
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    tick(1);
    check_reset_outputs("rst_rel");

    // 0x5A with echo.
    bus.echo_en = 1'b1;
    fork
      send_frame(8'h5A, 0);
      watch_tx(1'b1, 8'h5A, 300);
    join
    m_push(8'h5A);
    check("5a_ledr", bus.ledr, m_ledr);
    check_scan("5a_scan");

    // Five bytes through a four-deep history: 0x11 falls off.
    bus.echo_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i * 8'h11), 0);
      m_push(8'(i * 8'h11));
    end
    tick(2);
    check("seq_ledr", bus.ledr, m_ledr);
    check_scan("seq_scan");

    // 3-clock glitch records nothing; the following byte is received normally.
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(30);
    check("glitch_ledr", bus.ledr, m_ledr);
    check("glitch_frm", bus.frm_err, 1'b0);
    send_frame(8'hA3, 0);
    m_push(8'hA3);
    tick(2);
    check("a3_ledr", bus.ledr, m_ledr);
    check_scan("a3_scan");

    // Stop bit held low: framing error, history and ledr untouched, then cleared.
    send_frame(8'h81, 30);
    tick(2);
    check("frm_set", bus.frm_err, 1'b1);
    check("frm_ledr", bus.ledr, m_ledr);
    check_scan("frm_scan");
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
    check("frm_clr", bus.frm_err, 1'b0);

    // Randomised bytes with random echo enable, spaced so an echo always completes.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(255, 0));
      re = 1'($urandom_range(1, 0));
      bus.echo_en = re;
      fork
        send_frame(rb, 0);
        watch_tx(re, rb, re ? 300 : 150);
      join
      m_push(rb);
      check("rand_ledr", bus.ledr, m_ledr);
      tick(int'($urandom_range(40, 5)));
    end
    check("rand_ovr", bus.ovr, 1'b0);
    check_scan("rand_scan");

    // Back-to-back with echo: first echoed, second dropped and flagged.
    bus.echo_en = 1'b1;
    fork
      begin
        send_frame(8'h3C, 0);
        send_frame(8'hE7, 0);
      end
      begin
        watch_tx(1'b1, 8'h3C, 300);
        watch_tx(1'b0, 8'h00, 150);
      end
    join
    m_push(8'h3C);
    m_push(8'hE7);
    check("b2b_ovr", bus.ovr, 1'b1);
    check("b2b_ledr", bus.ledr, m_ledr);
    check("b2b_frm", bus.frm_err, 1'b0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
    check("ovr_clr", bus.ovr, 1'b0);

    // Reset in the middle of the second frame while the first echo drives tx low.
    fork
      begin
        send_frame(8'h00, 0);
        send_frame(8'hC6, 0);
      end
    join_none
    tick(150);
    check("pre_rst_busy", bus.tx_busy, 1'b1);
    check("pre_rst_tx", bus.tx, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick(70);
    check_reset_outputs("rst_long");
    bus.rx = 1'b1;
    rst = 1'b1;
    m_reset();
    tick(1);
    check_reset_outputs("rst_rel2");
    check_scan("post_rst_scan");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
